btn_scan_ctrl: RTL
==================

Name: btn_scan_ctrl

Overview:
- Debounce controller for NUM_BTN pushbuttons that share one settle timer. A round-robin scheduler grants the timer to one button at a time.
- Maintains a stable debounced level per button and reports each committed press or release as an event over a valid/ready handshake.
- Sits between the board pushbutton pins and the UI/control logic. Replaces one debouncer instance per button.

Parameters:
- NUM_BTN, 4, number of buttons (>=2).
- CLK_FREQ_HZ, 50_000_000, clk frequency in Hz.
- DEBOUNCE_US, 10_000, required stable time in microseconds.
- ACTIVE_LOW, 0, 1 = raw pins pressed when low (applies to all buttons).
- Derived: SETTLE_CYCLES = max(2, (CLK_FREQ_HZ/1_000_000)*DEBOUNCE_US); CNT_W = $clog2(SETTLE_CYCLES); IDW = max(1, $clog2(NUM_BTN)).

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous, active-low reset
- btn_raw  input  NUM_BTN  raw, asynchronous button pins
- btn_level  output  NUM_BTN  debounced level per button, 1 = pressed
- evt_valid  output  1  event available
- evt_ready  input  1  consumer accepts event
- evt_id  output  IDW  button index of event
- evt_press  output  1  1 = press, 0 = release
- busy  output  1  scheduler not in IDLE

Behaviour:
- Reset values:
  - btn_level = 0, evt_valid = 0, evt_id = 0, evt_press = 0, busy = 0.
  - Round-robin pointer ptr = 0, counter = 0, state = IDLE.
  - Synchronizer flops reset to the idle pin level: 1 if ACTIVE_LOW, else 0.
- Input path:
  - 2-flop synchronizer per bit.
  - s[i] = sync2[i] XOR ACTIVE_LOW.
  - mismatch[i] = s[i] != btn_level[i].
- FSM states: IDLE, SETTLE, EMIT. busy = (state != IDLE).
- IDLE:
  - If any mismatch, select the first mismatching index searching ptr, ptr+1, ... with wrap NUM_BTN-1 -> 0.
  - Latch it as cur_id, clear the counter, go to SETTLE. Otherwise stay in IDLE.
- SETTLE:
  - If s[cur_id] == btn_level[cur_id] (bounce): go to IDLE, no event, ptr = cur_id+1 (wrapped).
  - Else if counter == SETTLE_CYCLES-1:
    - Toggle btn_level[cur_id].
    - Load evt_id = cur_id and evt_press = new level; set evt_valid = 1.
    - Go to EMIT.
  - Else counter++.
- EMIT:
  - evt_valid, evt_id and evt_press are held stable until a clock edge with evt_valid & evt_ready.
  - At that edge: evt_valid = 0, ptr = cur_id+1 (wrapped), go to IDLE.
  - With evt_ready tied high, evt_valid is exactly 1 cycle wide.
- Latency: a raw change held stable toggles btn_level and raises evt_valid SETTLE_CYCLES+3 rising edges after the first edge that samples it (2 sync + 1 IDLE->SETTLE + SETTLE_CYCLES).
- Only the granted button is timed. Other mismatches stay pending and are arbitrated at the next IDLE.
- A glitch on another button that ends before its grant produces no event.
- At most one event is outstanding; there is no event queue.
- evt_ready while evt_valid = 0 is ignored.
- Counter never exceeds SETTLE_CYCLES-1; no wrap.
- n_rst asserted mid-SETTLE or mid-EMIT:
  - All state returns to reset values immediately, including btn_level.
  - A pending event is dropped.
  - Buttons still held after reset are re-debounced and reported as presses.

Test Plan:
Common config: NUM_BTN=4, CLK_FREQ_HZ=1_000_000, DEBOUNCE_US=8 (SETTLE_CYCLES=8), ACTIVE_LOW=0.
1. Reset with btn_raw=0 -> all outputs 0 and busy=0; no event over 50 cycles.
2. Clean press: btn_raw[2] rises and holds, evt_ready=1 -> btn_level[2] and evt_valid rise together 11 edges later; evt_id=2, evt_press=1; valid high exactly 1 cycle. Release then gives evt_press=0 after 11 edges.
3. Bounce: btn_raw[1] high 5 cycles, low 3 cycles, then high and held -> no event for the 5-cycle pulse; exactly one press event, id=1, committed 11 edges after the final rise.
4. Fairness: after scenario 2 (ptr=3), raise btn_raw[0] and btn_raw[3] on the same edge -> event id=3 first, then id=0 about 10 cycles after the first is accepted; ptr wraps to 0 then 1.
5. Backpressure: evt_ready=0 for 20 cycles during a press on btn 0 while btn 1 is also pressed -> evt_valid, evt_id=0 and evt_press=1 held stable. btn 1's press is reported only after the accepting edge.
6. Reset mid-SETTLE (n_rst low for 2 cycles on counter=4) -> no event, btn_level=0. Separate instance with ACTIVE_LOW=1 and btn_raw idle high from reset -> no events; pulling btn_raw[0] low for 20 cycles -> one press event, id=0.

Source files
------------

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: debounces NUM_BTN pushbuttons with one shared settle timer.
// A round-robin scheduler grants the timer; committed changes leave as valid/ready events.
module btn_scan_ctrl #(
    parameter int NUM_BTN     = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_US = 10_000,
    parameter int ACTIVE_LOW  = 0,
    localparam int SETTLE_RAW    = (CLK_FREQ_HZ / 1_000_000) * DEBOUNCE_US,
    localparam int SETTLE_CYCLES = (SETTLE_RAW < 2) ? 2 : SETTLE_RAW,
    localparam int CNT_W         = $clog2(SETTLE_CYCLES),
    localparam int IDW           = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDW-1:0]     evt_id,
    output logic               evt_press,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    // Level a released pin rests at; the synchronizer starts there so reset never looks like a press.
    localparam logic [NUM_BTN-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDW-1:0]     ID_LAST  = IDW'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] s_s;
    logic [NUM_BTN-1:0] mismatch_s;

    logic [1:0]         state_r;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     cur_id_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [1:0]         state_nxt_s;
    logic [IDW-1:0]     ptr_nxt_s;
    logic [IDW-1:0]     cur_id_nxt_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [NUM_BTN-1:0] level_nxt_s;
    logic               valid_nxt_s;
    logic [IDW-1:0]     id_nxt_s;
    logic               press_nxt_s;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
        logic [IDW-1:0] nxt;
        nxt = (id == ID_LAST) ? {IDW{1'b0}} : (id + IDW'(1'b1));
        return nxt;
    endfunction

    // First requester at or after start, wrapping; iterating downward lets the nearest one win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_BTN-1:0] req,
                                               input logic [IDW-1:0]     start);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        pick = start;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            idx  = IDW'((int'(start) + k) % NUM_BTN);
            pick = req[idx] ? idx : pick;
        end
        return pick;
    endfunction

    assign s_s        = sync2_r ^ PIN_IDLE;
    assign mismatch_s = s_s ^ btn_level;

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_r <= PIN_IDLE;
            sync2_r <= PIN_IDLE;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Scheduler next-state: grant, settle timing and event hand-off.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        cur_id_nxt_s = cur_id_r;
        cnt_nxt_s    = cnt_r;
        level_nxt_s  = btn_level;
        valid_nxt_s  = evt_valid;
        id_nxt_s     = evt_id;
        press_nxt_s  = evt_press;
        case (state_r)
            ST_IDLE: begin
                if (|mismatch_s) begin
                    cur_id_nxt_s = rr_pick(mismatch_s, ptr_r);
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    state_nxt_s  = ST_SETTLE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (s_s[cur_id_r] == btn_level[cur_id_r]) begin
                    ptr_nxt_s   = wrap_inc(cur_id_r);
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    level_nxt_s[cur_id_r] = ~btn_level[cur_id_r];
                    id_nxt_s    = cur_id_r;
                    press_nxt_s = ~btn_level[cur_id_r];
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_EMIT;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_EMIT: begin
                if (evt_valid && evt_ready) begin
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = wrap_inc(cur_id_r);
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {IDW{1'b0}};
            cur_id_r  <= {IDW{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            btn_level <= {NUM_BTN{1'b0}};
            evt_valid <= 1'b0;
            evt_id    <= {IDW{1'b0}};
            evt_press <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cur_id_r  <= cur_id_nxt_s;
            cnt_r     <= cnt_nxt_s;
            btn_level <= level_nxt_s;
            evt_valid <= valid_nxt_s;
            evt_id    <= id_nxt_s;
            evt_press <= press_nxt_s;
            busy      <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule
